// File: rtl/cache_refill_bridge.sv
// Line-refill engine: turns one cache miss into a 4-beat ascending read burst and returns the 128-bit line.
// Define REFILL_LINE_BUF_EN to add a single-entry buffer that answers repeat requests without memory traffic.
module cache_refill_bridge (
   input  logic         clk,
   input  logic         rst,
   input  logic         rd_req,
   input  logic [31:0]  rd_addr,
   output logic         ret_valid,
   output logic [127:0] ret_data,
   output logic         mem_arvalid,
   output logic [31:0]  mem_araddr,
   input  logic         mem_arready,
   input  logic         mem_rvalid,
   input  logic [31:0]  mem_rdata,
   output logic         mem_rready,
   input  logic         buf_inv
);

   typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

   state_t       state_q, state_d;
   logic [27:0]  tag_q, tag_d;
   logic [1:0]   beat_cnt_q, beat_cnt_d;
   logic [95:0]  asm_q, asm_d;
   logic [127:0] ret_data_q, ret_data_d;
   logic         hit;
   logic         unused_ok;

   // NOTE: every output and next-state value gets a default first, so no path can infer a latch.
   always_comb begin
      state_d     = state_q;
      tag_d       = tag_q;
      beat_cnt_d  = beat_cnt_q;
      asm_d       = asm_q;
      ret_data_d  = ret_data_q;
      ret_valid   = 1'b0;
      mem_arvalid = 1'b0;
      mem_rready  = 1'b0;
      case (state_q)
         IDLE: begin
            if (rd_req) begin
               tag_d   = rd_addr[31:4];
               state_d = hit ? RESP : ADDR;
            end
         end
         ADDR: begin
            mem_arvalid = 1'b1;
            if (mem_arready) state_d = DATA;
         end
         DATA: begin
            mem_rready = 1'b1;
            if (mem_rvalid) begin
               beat_cnt_d = beat_cnt_q + 2'd1;
               case (beat_cnt_q)
                  2'd0: asm_d[31:0]  = mem_rdata;
                  2'd1: asm_d[63:32] = mem_rdata;
                  2'd2: asm_d[95:64] = mem_rdata;
                  default: begin
                     // Last beat lands directly in the returned line, so ret_data only changes on entry to RESP.
                     ret_data_d = {mem_rdata, asm_q};
                     state_d    = RESP;
                  end
               endcase
            end
         end
         RESP: begin
            ret_valid = 1'b1;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so all registers update together at the edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         tag_q      <= '0;
         beat_cnt_q <= '0;
         ret_data_q <= '0;
      end else begin
         state_q    <= state_d;
         tag_q      <= tag_d;
         beat_cnt_q <= beat_cnt_d;
         ret_data_q <= ret_data_d;
      end
   end

   // NOTE: the assembly words carry no reset; all three are rewritten before any of them can reach ret_data.
   always_ff @(posedge clk) begin
      asm_q <= asm_d;
   end

`ifdef REFILL_LINE_BUF_EN
   // The buffered line is always the last RESP payload, so ret_data_q doubles as the buffer data.
   logic        buf_valid_q, buf_valid_d;
   logic [27:0] buf_tag_q, buf_tag_d;

   assign hit = buf_valid_q && (buf_tag_q == rd_addr[31:4]);

   always_comb begin
      buf_valid_d = buf_valid_q;
      buf_tag_d   = buf_tag_q;
      if (buf_inv) begin
         buf_valid_d = 1'b0;
      end else if (state_q == RESP) begin
         buf_valid_d = 1'b1;
         buf_tag_d   = tag_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         buf_valid_q <= 1'b0;
         buf_tag_q   <= '0;
      end else begin
         buf_valid_q <= buf_valid_d;
         buf_tag_q   <= buf_tag_d;
      end
   end

   assign unused_ok = ^rd_addr[3:0];
`else
   assign hit       = 1'b0;
   assign unused_ok = ^{buf_inv, rd_addr[3:0]};
`endif

   assign ret_data   = ret_data_q;
   assign mem_araddr = {tag_q, 4'b0000};

endmodule

// File: tb/tb_cache_refill_bridge.sv
// Self-checking bench for cache_refill_bridge: a reactive memory model drives randomized stalls and stray beats,
// and expected latency, address and line are computed from the refill rules rather than from the design.
module tb_cache_refill_bridge;

   logic         clk = 1'b0;
   logic         rst;
   logic         rd_req;
   logic [31:0]  rd_addr;
   logic         ret_valid;
   logic [127:0] ret_data;
   logic         mem_arvalid;
   logic [31:0]  mem_araddr;
   logic         mem_arready;
   logic         mem_rvalid;
   logic [31:0]  mem_rdata;
   logic         mem_rready;
   logic         buf_inv;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   cache_refill_bridge dut (
      .clk         (clk),
      .rst         (rst),
      .rd_req      (rd_req),
      .rd_addr     (rd_addr),
      .ret_valid   (ret_valid),
      .ret_data    (ret_data),
      .mem_arvalid (mem_arvalid),
      .mem_araddr  (mem_araddr),
      .mem_arready (mem_arready),
      .mem_rvalid  (mem_rvalid),
      .mem_rdata   (mem_rdata),
      .mem_rready  (mem_rready),
      .buf_inv     (buf_inv)
   );

   // Plays both the cache (request, hold/drop rules) and the memory (stalls, gaps, stray beats) for one refill.
   // Cycle 0 is the cycle in which rd_req is first sampled; outputs are observed at each falling edge.
   task automatic run_refill(
      input  logic [31:0]  addr,
      input  logic [127:0] line,
      input  int           ar_stall,
      input  int           g0, input int g1, input int g2, input int g3,
      input  bit           hold_req,
      input  bit           inv_in_resp,
      output int           ret_cyc,
      output logic [127:0] ret_line,
      output int           pulses,
      output int           ar_cycles,
      output bit           addr_ok,
      output logic         post_arvalid
   );
      int gaps [4];
      int idx;
      int gap_left;
      int stall_left;
      gaps[0] = g0; gaps[1] = g1; gaps[2] = g2; gaps[3] = g3;
      idx = 0; gap_left = g0; stall_left = ar_stall;
      ret_cyc = -1; ret_line = '0; pulses = 0; ar_cycles = 0; addr_ok = 1'b1; post_arvalid = 1'bx;
      @(negedge clk);
      for (int cyc = 0; cyc < 120; cyc++) begin
         if (cyc > 0) @(negedge clk);
         if (ret_valid) begin
            pulses++;
            if (ret_cyc < 0) begin
               ret_cyc  = cyc;
               ret_line = ret_data;
            end
         end
         if (ret_cyc >= 0 && cyc == ret_cyc + 2) post_arvalid = mem_arvalid;
         if (mem_arvalid) begin
            ar_cycles++;
            if (mem_araddr !== (addr & 32'hFFFF_FFF0)) addr_ok = 1'b0;
            if (stall_left > 0) begin
               mem_arready = 1'b0;
               stall_left--;
            end else begin
               mem_arready = 1'b1;
            end
         end else begin
            mem_arready = 1'($urandom_range(0, 1));
         end
         if (mem_rready) begin
            if (gap_left > 0) begin
               mem_rvalid = 1'b0;
               mem_rdata  = $urandom;
               gap_left--;
            end else if (idx < 4) begin
               mem_rvalid = 1'b1;
               mem_rdata  = line[32*idx +: 32];
               idx++;
               gap_left = (idx < 4) ? gaps[idx] : 0;
            end else begin
               mem_rvalid = 1'b1;
               mem_rdata  = $urandom;
            end
         end else begin
            mem_rvalid = 1'($urandom_range(0, 1));
            mem_rdata  = $urandom;
         end
         if (cyc == 0) begin
            rd_req  = 1'b1;
            rd_addr = addr;
         end else begin
            rd_addr = (ret_cyc < 0) ? $urandom : addr;
         end
         if (ret_valid) begin
            if (!hold_req) rd_req = 1'b0;
            buf_inv = inv_in_resp;
         end else begin
            buf_inv = 1'b0;
         end
         if (ret_cyc >= 0 && cyc >= ret_cyc + 3) break;
      end
      mem_arready = 1'b0;
      mem_rvalid  = 1'b0;
      buf_inv     = 1'b0;
   endtask

   task automatic pulse_reset;
      @(negedge clk);
      rst    = 1'b1;
      rd_req = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic inv_buffer;
      @(negedge clk);
      buf_inv = 1'b1;
      @(negedge clk);
      buf_inv = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1; rd_req = 1'b0; rd_addr = 32'hFFFF_FFFF; mem_arready = 1'b1;
      mem_rvalid = 1'b1; mem_rdata = 32'hA5A5_A5A5; buf_inv = 1'b0;
      repeat (2) @(negedge clk);
      n_cmp++; if (ret_valid !== 1'b0) begin n_bad++; $display("FAIL reset_ret_valid: got %b want 0", ret_valid); end
      n_cmp++; if (ret_data !== 128'h0) begin n_bad++; $display("FAIL reset_ret_data: got %h want 0", ret_data); end
      n_cmp++; if (mem_arvalid !== 1'b0) begin n_bad++; $display("FAIL reset_arvalid: got %b want 0", mem_arvalid); end
      n_cmp++; if (mem_araddr !== 32'h0) begin n_bad++; $display("FAIL reset_araddr: got %h want 0", mem_araddr); end
      n_cmp++; if (mem_rready !== 1'b0) begin n_bad++; $display("FAIL reset_rready: got %b want 0", mem_rready); end
      rst = 1'b0; mem_rvalid = 1'b0; mem_arready = 1'b0;
   endtask

   task automatic test_basic;
      int rc, pl, ac; bit aok; logic pa; logic [127:0] got;
      logic [127:0] exp_line = 128'h34567891_02345678_91023456_78910234;
      run_refill(32'hDEBA_D00C, exp_line, 0, 0, 0, 0, 0, 1'b0, 1'b0, rc, got, pl, ac, aok, pa);
      n_cmp++; if (rc !== 6) begin n_bad++; $display("FAIL basic_latency: got %0d want 6", rc); end
      n_cmp++; if (got !== exp_line) begin n_bad++; $display("FAIL basic_data: got %h want %h", got, exp_line); end
      n_cmp++; if (aok !== 1'b1 || ac !== 1) begin n_bad++; $display("FAIL basic_araddr: ok %b cycles %0d want ok 1 cycles 1", aok, ac); end
      n_cmp++; if (pl !== 1) begin n_bad++; $display("FAIL basic_pulses: got %0d want 1", pl); end
   endtask

   task automatic test_stall;
      int rc, pl, ac; bit aok; logic pa; logic [127:0] got;
      logic [127:0] exp_line = 128'h34567891_02345678_91023456_78910234;
      inv_buffer();
      run_refill(32'hDEBA_D00C, exp_line, 3, 0, 2, 2, 2, 1'b0, 1'b0, rc, got, pl, ac, aok, pa);
      n_cmp++; if (rc !== 15) begin n_bad++; $display("FAIL stall_latency: got %0d want 15", rc); end
      n_cmp++; if (got !== exp_line) begin n_bad++; $display("FAIL stall_data: got %h want %h", got, exp_line); end
      n_cmp++; if (aok !== 1'b1 || ac !== 4) begin n_bad++; $display("FAIL stall_araddr: ok %b cycles %0d want ok 1 cycles 4", aok, ac); end
   endtask

   task automatic test_reset_abort;
      int n; int bad_cycles; int rc, pl, ac; bit aok; logic pa; logic [127:0] got;
      logic [127:0] new_line = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      rd_req = 1'b1; rd_addr = 32'hCAFE_0004; mem_arready = 1'b1; mem_rvalid = 1'b0;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!mem_rready && n < 20);
      n_cmp++; if (mem_rready !== 1'b1) begin n_bad++; $display("FAIL abort_reach_data: rready %b after %0d cycles", mem_rready, n); end
      for (int b = 0; b < 2; b++) begin
         mem_rvalid = 1'b1;
         mem_rdata  = $urandom;
         @(negedge clk);
      end
      rst = 1'b1; rd_req = 1'b0; mem_rdata = $urandom;
      @(negedge clk);
      rst = 1'b0;
      n_cmp++; if (ret_data !== 128'h0) begin n_bad++; $display("FAIL abort_ret_data: got %h want 0", ret_data); end
      bad_cycles = 0;
      for (int c = 0; c < 5; c++) begin
         if (ret_valid !== 1'b0 || mem_rready !== 1'b0 || mem_arvalid !== 1'b0) bad_cycles++;
         mem_rvalid = 1'b1;
         mem_rdata  = $urandom;
         @(negedge clk);
      end
      mem_rvalid = 1'b0; mem_arready = 1'b0;
      n_cmp++; if (bad_cycles !== 0) begin n_bad++; $display("FAIL abort_quiet: %0d busy cycles want 0", bad_cycles); end
      run_refill(32'h0000_1010, new_line, 0, 0, 0, 0, 0, 1'b0, 1'b0, rc, got, pl, ac, aok, pa);
      n_cmp++; if (rc !== 6) begin n_bad++; $display("FAIL abort_new_latency: got %0d want 6", rc); end
      n_cmp++; if (got !== new_line) begin n_bad++; $display("FAIL abort_new_data: got %h want %h", got, new_line); end
      n_cmp++; if (aok !== 1'b1) begin n_bad++; $display("FAIL abort_new_araddr: ok %b want 1", aok); end
   endtask

   task automatic test_hold_drop;
      int rc, pl, ac; bit aok; logic pa; logic [127:0] got;
      logic [127:0] line = {$urandom, $urandom, $urandom, $urandom};
      run_refill(32'h4000_0020, line, 0, 0, 0, 0, 0, 1'b1, 1'b1, rc, got, pl, ac, aok, pa);
      n_cmp++; if (rc !== 6 || got !== line) begin n_bad++; $display("FAIL hold_first: latency %0d data %h want 6 %h", rc, got, line); end
      n_cmp++; if (pa !== 1'b1) begin n_bad++; $display("FAIL hold_second_burst: arvalid %b want 1", pa); end
      n_cmp++; if (aok !== 1'b1) begin n_bad++; $display("FAIL hold_araddr: ok %b want 1", aok); end
      pulse_reset();
      run_refill(32'h4000_0020, line, 1, 1, 0, 1, 0, 1'b0, 1'b0, rc, got, pl, ac, aok, pa);
      n_cmp++; if (rc !== 9 || got !== line) begin n_bad++; $display("FAIL drop_line: latency %0d data %h want 9 %h", rc, got, line); end
      n_cmp++; if (pa !== 1'b0) begin n_bad++; $display("FAIL drop_idle: arvalid %b want 0", pa); end
      n_cmp++; if (pl !== 1) begin n_bad++; $display("FAIL drop_pulses: got %0d want 1", pl); end
   endtask

   task automatic test_random;
      int rc, pl, ac; bit aok; logic pa; logic [127:0] got;
      int s, g0, g1, g2, g3;
      logic [31:0] addr;
      logic [127:0] line;
      for (int it = 0; it < 8; it++) begin
         addr = $urandom;
         line = {$urandom, $urandom, $urandom, $urandom};
         s  = $urandom_range(0, 3);
         g0 = $urandom_range(0, 3); g1 = $urandom_range(0, 3);
         g2 = $urandom_range(0, 3); g3 = $urandom_range(0, 3);
         run_refill(addr, line, s, g0, g1, g2, g3, 1'b0, 1'b0, rc, got, pl, ac, aok, pa);
         n_cmp++; if (rc !== 6 + s + g0 + g1 + g2 + g3) begin n_bad++; $display("FAIL rand%0d_latency: got %0d want %0d", it, rc, 6 + s + g0 + g1 + g2 + g3); end
         n_cmp++; if (got !== line) begin n_bad++; $display("FAIL rand%0d_data: got %h want %h", it, got, line); end
         n_cmp++; if (aok !== 1'b1 || ac !== s + 1) begin n_bad++; $display("FAIL rand%0d_araddr: ok %b cycles %0d want ok 1 cycles %0d", it, aok, ac, s + 1); end
         n_cmp++; if (pl !== 1 || pa !== 1'b0) begin n_bad++; $display("FAIL rand%0d_single: pulses %0d arvalid %b want 1 0", it, pl, pa); end
      end
   endtask

`ifdef REFILL_LINE_BUF_EN
   task automatic test_buffer_hit;
      int rc, pl, ac; bit aok; logic pa; logic [127:0] got;
      logic [127:0] line_a = {$urandom, $urandom, $urandom, $urandom};
      logic [127:0] line_b = ~line_a;
      inv_buffer();
      run_refill(32'hDEBA_D000, line_a, 0, 0, 0, 0, 0, 1'b0, 1'b0, rc, got, pl, ac, aok, pa);
      n_cmp++; if (rc !== 6 || got !== line_a) begin n_bad++; $display("FAIL buf_fill: latency %0d data %h want 6 %h", rc, got, line_a); end
      run_refill(32'hDEBA_D008, line_b, 0, 0, 0, 0, 0, 1'b0, 1'b0, rc, got, pl, ac, aok, pa);
      n_cmp++; if (rc !== 1) begin n_bad++; $display("FAIL buf_hit_latency: got %0d want 1", rc); end
      n_cmp++; if (got !== line_a) begin n_bad++; $display("FAIL buf_hit_data: got %h want %h", got, line_a); end
      n_cmp++; if (ac !== 0) begin n_bad++; $display("FAIL buf_hit_no_burst: %0d address cycles want 0", ac); end
   endtask

   task automatic test_buffer_inv;
      int rc, pl, ac; bit aok; logic pa; logic [127:0] got;
      logic [127:0] line_c = {$urandom, $urandom, $urandom, $urandom};
      inv_buffer();
      run_refill(32'hDEBA_D000, line_c, 0, 0, 0, 0, 0, 1'b0, 1'b0, rc, got, pl, ac, aok, pa);
      n_cmp++; if (rc !== 6 || ac !== 1) begin n_bad++; $display("FAIL buf_inv_burst: latency %0d address cycles %0d want 6 1", rc, ac); end
      n_cmp++; if (got !== line_c) begin n_bad++; $display("FAIL buf_inv_data: got %h want %h", got, line_c); end
   endtask
`else
   task automatic test_no_buffer;
      int rc, pl, ac; bit aok; logic pa; logic [127:0] got;
      logic [127:0] line_a = {$urandom, $urandom, $urandom, $urandom};
      logic [127:0] line_b = ~line_a;
      run_refill(32'hDEBA_D000, line_a, 0, 0, 0, 0, 0, 1'b0, 1'b0, rc, got, pl, ac, aok, pa);
      run_refill(32'hDEBA_D008, line_b, 0, 0, 0, 0, 0, 1'b0, 1'b1, rc, got, pl, ac, aok, pa);
      n_cmp++; if (rc !== 6 || ac !== 1) begin n_bad++; $display("FAIL nobuf_burst: latency %0d address cycles %0d want 6 1", rc, ac); end
      n_cmp++; if (got !== line_b) begin n_bad++; $display("FAIL nobuf_data: got %h want %h", got, line_b); end
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_stall();
      test_reset_abort();
      test_hold_drop();
      test_random();
`ifdef REFILL_LINE_BUF_EN
      test_buffer_hit();
      test_buffer_inv();
`else
      test_no_buffer();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/cache_refill_bridge.md
# cache_refill_bridge

Line-refill engine between the read-only cache's miss port and a 32-bit burst memory port. It accepts one line request from the cache and issues a line-aligned 4-beat read burst. It assembles the four 32-bit beats into a 128-bit line and returns it to the cache with a one-cycle `ret_valid` pulse. It sits directly downstream of the cache's `rd_req`/`rd_addr` port and upstream of the memory interconnect.

## Interface
Parameters: none; line is fixed at 128 bits and 4 beats, the address is 32 bits.
- `clk`  in  1  single clock; all state updates on the rising edge
- `rst`  in  1  synchronous, active-high reset
- `rd_req`  in  1  refill request from cache; level, held until `ret_valid` is observed
- `rd_addr`  in  32  miss address; bits [3:0] ignored
- `ret_valid`  out  1  one-cycle pulse; `ret_data` is valid in the same cycle
- `ret_data`  out  128  refilled line; word i occupies bits [32i+31:32i]
- `mem_arvalid`  out  1  burst address valid
- `mem_araddr`  out  32  `{rd_addr[31:4], 4'b0}`
- `mem_arready`  in  1  address accepted when high together with `mem_arvalid`
- `mem_rvalid`  in  1  read beat valid
- `mem_rdata`  in  32  read beat data
- `mem_rready`  out  1  high only in DATA
- `buf_inv`  in  1  invalidates the line buffer; ignored when the buffer is compiled out

## Operation
- FSM states and transitions:
  - IDLE: when `rd_req`=1, latch `rd_addr[31:4]` and go to ADDR. With the buffer compiled in and hitting, go to RESP instead.
  - ADDR: `mem_arvalid`=1 with the latched aligned address. On `mem_arready`, go to DATA.
  - DATA: `mem_rready`=1. Each `mem_rvalid` beat is written to word slot `beat_cnt` (2-bit), then `beat_cnt` increments. The 4th beat (`beat_cnt`=3) goes to RESP and wraps `beat_cnt` to 0.
  - RESP: `ret_valid`=1 for exactly one cycle, then go to IDLE.
- Burst order is ascending: beat 0 is the word at the aligned address.
- `rd_req` is only examined in IDLE. Changes to `rd_addr` after latching have no effect.
- Handshake contract: the cache drops `rd_req` on the same edge at which it samples `ret_valid`=1. A request still held in the IDLE cycle after RESP is treated as a new request.
- `ret_data` holds its value until the next RESP.
- Beats arriving outside DATA are not accepted (`mem_rready`=0). `mem_rlast` is not used; the line completes on the 4-beat count.

## Timing
- Reset values: state IDLE, `ret_valid`=0, `ret_data`=0, `mem_arvalid`=0, `mem_araddr`=0, `mem_rready`=0, `beat_cnt`=0, buffer valid=0.
- Minimum miss latency, with `mem_arready`=1 and `mem_rvalid`=1 every cycle:
  - request sampled in cycle 0;
  - ADDR in cycle 1;
  - DATA in cycles 2–5;
  - `ret_valid` in cycle 6.
- Each stall cycle of `mem_arready` or `mem_rvalid` adds one cycle.
- `mem_arvalid` stays high and `mem_araddr` stays stable until `mem_arready`.
- `rst` in any state returns to IDLE at the next edge. It aborts the burst, discards partial data and clears the buffer valid bit. Subsequent stray beats are not accepted.

## Configuration
- `REFILL_LINE_BUF_EN` defined:
  - A single-entry buffer holds the tag (`rd_addr[31:4]`) and data of the last completed line.
  - In IDLE, a request whose tag matches a valid entry goes straight to RESP, returning buffered data with no memory traffic; `ret_valid` appears in cycle 1.
  - The buffer is filled on every RESP from a memory refill.
  - `buf_inv`=1 clears valid at the next edge, takes priority over a same-cycle fill, and is ignored in no other case.
- `REFILL_LINE_BUF_EN` not defined:
  - The buffer is absent and `buf_inv` is ignored.
  - Every request issues a memory burst.

## Test plan
- Reset, then `rd_req`=1 with `rd_addr`=32'hDEBA_D00C; memory returns beats 78910234, 91023456, 02345678, 34567891 with no stalls. Required:
  - `mem_araddr`=32'hDEBA_D000;
  - `ret_valid` pulses once in cycle 6;
  - `ret_data`=128'h34567891_02345678_91023456_78910234.
- Same request with `mem_arready` low for 3 cycles and `mem_rvalid` gapped 2 cycles between each beat. Required: the same line, `ret_valid` in cycle 15, and `mem_araddr` stable throughout ADDR.
- Assert `rst` after 2 beats, then make a fresh request to 32'h0000_1010. Required: no `ret_valid` from the aborted burst, and the new line is assembled from new beats only.
- Hold `rd_req` through RESP. Required: a second burst starts. Drop `rd_req` on the `ret_valid` edge. Required: FSM idles with `mem_arvalid`=0.
- With `REFILL_LINE_BUF_EN`: refill 32'hDEBA_D000, then request 32'hDEBA_D008. Required: `ret_valid` in cycle 1, the same data, and no `mem_arvalid`.
- With `REFILL_LINE_BUF_EN`: refill 32'hDEBA_D000, pulse `buf_inv`, then request the same line. Required: a full memory burst.
